// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, fetches over req/ack,
// holds the instruction for decode and picks the next PC at retire.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [31:0]      pc,
  output logic [31:0]      pcplus4,
  input  logic             instr_ready,
  input  logic             pcsrc,
  input  logic             jump,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [CNT_W-1:0] r_retired;
  logic [31:0]      w_pcplus4;
  logic [31:0]      w_brofs;
  logic [31:0]      w_next_pc;
  logic             w_take;
  logic             w_retire;

  assign w_pcplus4 = r_pc + 32'd4;
  assign w_brofs   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  // jump wins over branch when both are asserted
  always_comb begin
    w_next_pc = w_pcplus4;
    if (jump) begin
      w_next_pc = {w_pcplus4[31:28], r_instr[25:0], 2'b00};
    end else if (pcsrc) begin
      w_next_pc = w_pcplus4 + w_brofs;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_take      = 1'b0;
    w_retire    = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_take = 1'b1;
          w_next = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          w_retire = 1'b1;
          w_next   = FETCH;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= 32'd0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_instr <= imem_rdata;
      end
      if (w_retire) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign pcplus4   = w_pcplus4;
  assign instr     = r_instr;
  assign op        = r_instr[31:26];
  assign funct     = r_instr[5:0];
  assign retired   = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic,
// checked against a phase-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        instr_ready = 1'b0;
  logic        pcsrc = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] retired;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .op(op),
    .funct(funct),
    .pc(pc),
    .pcplus4(pcplus4),
    .instr_ready(instr_ready),
    .pcsrc(pcsrc),
    .jump(jump),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // phase: 0 = boot cycle, 1 = waiting on memory, 2 = holding instr
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ret;
  logic [31:0] w_word;
  logic [31:0] r0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_npc(input logic [31:0] p,
                                          input logic [31:0] ins,
                                          input logic ps,
                                          input logic jp);
    logic [31:0] seq;
    int          ofs;
    seq = p + 32'd4;
    ofs = int'($signed(ins[15:0])) * 4;
    if (jp) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (ps) return seq + 32'(ofs);
    return seq;
  endfunction

  task automatic check_all();
    check("req", 32'(imem_req), 32'(m_phase == 1));
    check("valid", 32'(instr_valid), 32'(m_phase == 2));
    check("inv", 32'(imem_req & instr_valid), 32'd0);
    check("addr", imem_addr, m_pc);
    check("pc", pc, m_pc);
    check("pcplus4", pcplus4, m_pc + 32'd4);
    check("instr", instr, m_instr);
    check("op", 32'(op), m_instr >> 26);
    check("funct", 32'(funct), m_instr & 32'h3F);
    check("retired", retired, m_ret);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc    = 32'd0;
    m_instr = 32'd0;
    m_ret   = 32'd0;
  endtask

  task automatic cyc(input logic a, input logic [31:0] rd,
                     input logic rdy, input logic ps, input logic jp);
    imem_ack    = a;
    imem_rdata  = rd;
    instr_ready = rdy;
    pcsrc       = ps;
    jump        = jp;
    @(posedge clk);
    case (m_phase)
      0: m_phase = 1;
      1: if (a) begin
        m_instr = rd;
        m_phase = 2;
      end
      default: if (rdy) begin
        m_ret   = m_ret + 32'd1;
        m_pc    = ref_npc(m_pc, m_instr, ps, jp);
        m_phase = 1;
      end
    endcase
    @(negedge clk);
    check_all();
  endtask

  task automatic fetch(input logic [31:0] w);
    cyc(1'b1, w, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic retire(input logic ps, input logic jp);
    cyc(1'b0, 32'h0, 1'b1, ps, jp);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    resetn = 1'b1;
    // boot cycle: ack here must be ignored
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    check("boot_addr", imem_addr, 32'h0);
    check("boot_req", 32'(imem_req), 32'd1);
    fetch(32'h0022_1820);
    check("add_op", 32'(op), 32'h00);
    check("add_funct", 32'(funct), 32'h20);
    check("boot_ret", retired, 32'd0);
    retire(1'b0, 1'b0);
    check("seq_addr", imem_addr, 32'h4);
    check("seq_ret", retired, 32'd1);
    fetch(32'h0800_0004);
    retire(1'b0, 1'b1);
    fetch(32'h1000_FFFC);
    retire(1'b1, 1'b0);
    check("br_taken", imem_addr, 32'h4);
    fetch(32'h0800_0004);
    retire(1'b0, 1'b1);
    fetch(32'h1000_FFFC);
    retire(1'b0, 1'b0);
    check("br_not", imem_addr, 32'h14);
    fetch(32'h0800_0008);
    retire(1'b0, 1'b1);
    fetch(32'h0800_0040);
    retire(1'b1, 1'b1);
    check("jmp_prio", imem_addr, 32'h100);
    // delayed ack, then stalled ready with spurious acks
    repeat (5) begin
      cyc(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
      check("wait_addr", imem_addr, 32'h100);
    end
    w_word = 32'h0043_2025;
    fetch(w_word);
    r0 = retired;
    repeat (4) begin
      cyc(1'b1, $urandom, 1'b0, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
      check("stall_instr", instr, w_word);
    end
    retire(1'b0, 1'b0);
    check("one_retire", retired, r0 + 32'd1);
    check("stall_next", imem_addr, 32'h104);
    fetch(32'h1000_FFBD);
    retire(1'b1, 1'b0);
    check("to_top", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_0000);
    check("wrap_p4", pcplus4, 32'h0);
    retire(1'b0, 1'b0);
    check("wrap_addr", imem_addr, 32'h0);
    repeat (3000) begin
      cyc(1'($urandom_range(0, 2) == 0), $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    end
    if (m_phase == 2) retire(1'b0, 1'b0);
    if (m_phase == 2) retire(1'b0, 1'b0);
    check("pre_rst_req", 32'(imem_req), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_ret", retired, 32'd0);
    check("rst_instr", instr, 32'd0);
    model_reset();
    @(negedge clk);
    check_all();
    resetn = 1'b1;
    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    fetch(32'h0000_0020);
    retire(1'b0, 1'b0);
    check("post_rst", imem_addr, 32'h4);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
